terrain_column_server: RTL

- Owns the playfield terrain and serves it one 480-pixel column at a time on terrain_data for the collider and bomb logic; it is the writer/provider side of the terrain_data column interface.
- Accepts crater requests over a req/ack handshake and carves them into stored terrain column by column.
- Terrain is stored as one surface-row value per column. A pixel is solid iff its row >= surface[col].

---
 rtl/terrain_column_server_if.sv | 24 ++
 rtl/terrain_column_server.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/terrain_column_server_if.sv
// rtl/terrain_column_server_if.sv - terrain column read and crater request bundle
interface terrain_column_server_if;
  logic [9:0]   DrawX;
  logic [479:0] terrain_data;
  logic         crater_req;
  logic [9:0]   crater_x;
  logic [9:0]   crater_y;
  logic [4:0]   crater_r;
  logic         crater_ack;
  logic         busy;
  logic         init_done;

  // client side: renderer / collider / bomb logic
  modport master (
    output DrawX, crater_req, crater_x, crater_y, crater_r,
    input  terrain_data, crater_ack, busy, init_done
  );

  // terrain owner
  modport slave (
    input  DrawX, crater_req, crater_x, crater_y, crater_r,
    output terrain_data, crater_ack, busy, init_done
  );
endinterface

// File: rtl/terrain_column_server.sv
// rtl/terrain_column_server.sv - terrain surface store, column server and crater carver
module terrain_column_server #(
  parameter int COLS   = 640,
  parameter int ROWS   = 480,
  parameter int H_INIT = 400,
  parameter int R_MAX  = 31
) (
  input  logic                    clk,
  input  logic                    reset_n,
  terrain_column_server_if.slave  bus
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_FIT, S_WRITE, S_DONE} state_t;

  state_t     state, state_n;
  logic [9:0] c, c_n;
  logic [9:0] c_end, c_end_n;
  logic [9:0] x_q, x_n;
  logic [9:0] y_q, y_n;
  logic [4:0] r_q, r_n;
  logic [4:0] h, h_n;
  logic       armed, armed_n;
  logic       init_done, init_done_n;

  // one surface row per column; ROWS means the column is empty
  logic [8:0] surface [COLS];
  logic [8:0] surf_q;

  logic       mem_we;
  logic [9:0] mem_wa;
  logic [8:0] mem_wd;

  logic [4:0]  r_in;
  logic [9:0]  acc_lo, acc_hi;
  logic [10:0] acc_sum;
  logic [9:0]  dx;
  logic [10:0] dx_sq, h_sq, r_sq, dist_sq;
  logic [10:0] depth;
  logic [8:0]  new_surf, cur_surf, carved;

  // request decode: clamp radius and the column span to the playfield
  always_comb begin
    r_in    = (bus.crater_r > 5'(R_MAX)) ? 5'(R_MAX) : bus.crater_r;
    acc_lo  = (bus.crater_x >= {5'd0, r_in}) ? (bus.crater_x - {5'd0, r_in}) : 10'd0;
    acc_sum = {1'b0, bus.crater_x} + {6'd0, r_in};
    acc_hi  = (acc_sum > 11'(COLS - 1)) ? 10'(COLS - 1) : acc_sum[9:0];
  end

  // circle fit and carve depth for the current column; dx <= r so 11 bits never overflow
  always_comb begin
    dx       = (c >= x_q) ? (c - x_q) : (x_q - c);
    dx_sq    = {1'b0, dx} * {1'b0, dx};
    h_sq     = {6'd0, h} * {6'd0, h};
    r_sq     = {6'd0, r_q} * {6'd0, r_q};
    dist_sq  = dx_sq + h_sq;
    depth    = {1'b0, y_q} + {6'd0, h} + 11'd1;
    new_surf = (depth >= 11'(ROWS)) ? 9'(ROWS) : depth[8:0];
    cur_surf = (c < 10'(COLS)) ? surface[c] : 9'(ROWS);
    // craters only ever remove material, so the surface row can only grow
    carved   = (new_surf > cur_surf) ? new_surf : cur_surf;
  end

  // next-state and write-port control
  always_comb begin
    state_n     = state;
    c_n         = c;
    c_end_n     = c_end;
    x_n         = x_q;
    y_n         = y_q;
    r_n         = r_q;
    h_n         = h;
    armed_n     = armed;
    init_done_n = init_done;
    mem_we      = 1'b0;
    mem_wa      = c;
    mem_wd      = carved;
    case (state)
      S_INIT: begin
        mem_we = 1'b1;
        mem_wd = 9'(H_INIT);
        if (c == 10'(COLS - 1)) begin
          c_n         = 10'd0;
          init_done_n = 1'b1;
          state_n     = S_IDLE;
        end else begin
          c_n = c + 10'd1;
        end
      end
      S_IDLE: begin
        if (!bus.crater_req) begin
          armed_n = 1'b1;
        end else if (armed && init_done) begin
          armed_n = 1'b0;
          x_n     = bus.crater_x;
          y_n     = bus.crater_y;
          r_n     = r_in;
          h_n     = r_in;
          c_n     = acc_lo;
          c_end_n = acc_hi;
          // a crater entirely off the right edge has an empty span
          state_n = (acc_lo > acc_hi) ? S_DONE : S_FIT;
        end
      end
      S_FIT: begin
        if (dist_sq > r_sq) begin
          h_n = h - 5'd1;
        end else begin
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (c == c_end) begin
          state_n = S_DONE;
        end else begin
          c_n     = c + 10'd1;
          h_n     = r_q;
          state_n = S_FIT;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_INIT;
      end
    endcase
  end

  // control and carve registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT;
      c         <= 10'd0;
      c_end     <= 10'd0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      r_q       <= 5'd0;
      h         <= 5'd0;
      armed     <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      c         <= c_n;
      c_end     <= c_end_n;
      x_q       <= x_n;
      y_q       <= y_n;
      r_q       <= r_n;
      h         <= h_n;
      armed     <= armed_n;
      init_done <= init_done_n;
    end
  end

  // single write port into the surface store
  always_ff @(posedge clk) begin
    if (mem_we) begin
      surface[mem_wa] <= mem_wd;
    end
  end

  // registered read port; a same-cycle write to this column is seen one cycle later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      surf_q <= 9'(ROWS);
    end else begin
      surf_q <= (bus.DrawX < 10'(COLS)) ? surface[bus.DrawX] : 9'(ROWS);
    end
  end

  // expand the served surface row into the solid-pixel column mask
  always_comb begin
    bus.terrain_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      bus.terrain_data[r] = (9'(r) >= surf_q);
    end
  end

  assign bus.busy       = (state != S_IDLE);
  assign bus.crater_ack = (state == S_DONE);
  assign bus.init_done  = init_done;

endmodule
